// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: shared CSR addresses, mstatus/mie bit indices, interrupt codes and FSM encoding
package csr_trap_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;
  localparam logic [4:0] IRQ_SW_CODE = 5'd3;
  localparam logic [4:0] IRQ_TMR_CODE = 5'd7;
  localparam logic [4:0] IRQ_EXT_CODE = 5'd11;
  typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, MRET_ST, JUMP} state_t;
endpackage

// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: pipeline-side request, live CSR values and CSR write/redirect outputs
interface csr_trap_ctrl_if #(parameter int XLEN = 32);
  logic except_i;
  logic [XLEN-1:0] except_cause_i;
  logic [XLEN-1:0] inst_addr_i;
  logic mret_i;
  logic irq_ext_i;
  logic irq_sw_i;
  logic irq_tmr_i;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mie_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  logic pipe_we_i;
  logic [11:0] pipe_waddr_i;
  logic [XLEN-1:0] pipe_wdata_i;
  logic csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic stall_o;
  logic flush_o;
  logic jump_o;
  logic [XLEN-1:0] jump_addr_o;
  modport master (
    output except_i, except_cause_i, inst_addr_i, mret_i, irq_ext_i, irq_sw_i, irq_tmr_i,
    output mstatus_i, mie_i, mtvec_i, mepc_i, pipe_we_i, pipe_waddr_i, pipe_wdata_i,
    input csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o, jump_o, jump_addr_o
  );
  modport slave (
    input except_i, except_cause_i, inst_addr_i, mret_i, irq_ext_i, irq_sw_i, irq_tmr_i,
    input mstatus_i, mie_i, mtvec_i, mepc_i, pipe_we_i, pipe_waddr_i, pipe_wdata_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o, jump_o, jump_addr_o
  );
endinterface

// File: rtl/csr_trap_ctrl_irq_prio.sv
// irq_prio: fixed-priority interrupt encoder, ext > sw > tmr, pending {ext,sw,tmr}
module irq_prio import csr_trap_ctrl_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      pend_i,
  input  logic [2:0]      en_i,
  output logic            valid_o,
  output logic [XLEN-1:0] cause_o
);
  logic [2:0] act;
  logic [4:0] code;
  // pick highest-priority enabled pending line
  always_comb begin
    act = pend_i & en_i;
    code = act[2] ? IRQ_EXT_CODE : act[1] ? IRQ_SW_CODE : IRQ_TMR_CODE;
  end
  assign valid_o = |act;
  assign cause_o = {1'b1, {(XLEN-6){1'b0}}, code};
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences trap entry / MRET through the single CSR write port and redirects the PC
module csr_trap_ctrl import csr_trap_ctrl_pkg::*; #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  csr_trap_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [XLEN-3:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic mret_q, mret_d;
  logic irq_valid, take_irq, accept, is_mret;
  logic [XLEN-1:0] irq_cause;
  logic we, stall, flush, jump;
  logic [11:0] waddr;
  logic [XLEN-1:0] wdata, jaddr, mst_trap, mst_mret, vec_base;
  irq_prio #(.XLEN(XLEN)) u_irq_prio (
    .pend_i ({bus.irq_ext_i, bus.irq_sw_i, bus.irq_tmr_i}),
    .en_i   ({bus.mie_i[MIE_MEIE], bus.mie_i[MIE_MSIE], bus.mie_i[MIE_MTIE]}),
    .valid_o(irq_valid),
    .cause_o(irq_cause)
  );
  // mstatus images for trap entry / return, and the redirect target
  always_comb begin
    mst_trap = bus.mstatus_i;
    mst_trap[MSTATUS_MPIE] = bus.mstatus_i[MSTATUS_MIE];
    mst_trap[MSTATUS_MIE] = 1'b0;
    mst_mret = bus.mstatus_i;
    mst_mret[MSTATUS_MIE] = bus.mstatus_i[MSTATUS_MPIE];
    mst_mret[MSTATUS_MPIE] = 1'b1;
    vec_base = {bus.mtvec_i[XLEN-1:2], 2'b00};
    jaddr = mret_q ? bus.mepc_i
          : (bus.mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1]) ? vec_base + XLEN'({cause_q[4:0], 2'b00})
          : vec_base;
  end
  // next state, latches and per-state write/redirect outputs
  always_comb begin
    take_irq = bus.mstatus_i[MSTATUS_MIE] & irq_valid;
    accept = bus.except_i | bus.mret_i | take_irq;
    is_mret = !bus.except_i & bus.mret_i;
    state_d = state_q;
    epc_d = epc_q;
    cause_d = cause_q;
    mret_d = mret_q;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    stall = 1'b1;
    flush = 1'b0;
    jump = 1'b0;
    case (state_q)
      IDLE: begin
        we = bus.pipe_we_i;
        waddr = bus.pipe_waddr_i;
        wdata = bus.pipe_wdata_i;
        stall = accept;
        flush = accept;
        if (accept) begin
          epc_d = bus.inst_addr_i[XLEN-1:2];
          cause_d = bus.except_i ? bus.except_cause_i : irq_cause;
          mret_d = is_mret;
          state_d = is_mret ? MRET_ST : W_MEPC;
        end
      end
      W_MEPC: begin
        we = 1'b1;
        waddr = CSR_MEPC;
        wdata = {epc_q, 2'b00};
        state_d = W_MCAUSE;
      end
      W_MCAUSE: begin
        we = 1'b1;
        waddr = CSR_MCAUSE;
        wdata = cause_q;
        state_d = W_MSTATUS;
      end
      W_MSTATUS: begin
        we = 1'b1;
        waddr = CSR_MSTATUS;
        wdata = mst_trap;
        state_d = JUMP;
      end
      MRET_ST: begin
        we = 1'b1;
        waddr = CSR_MSTATUS;
        wdata = mst_mret;
        state_d = JUMP;
      end
      JUMP: begin
        jump = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and latched epc/cause; reset aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q <= '0;
      cause_q <= '0;
      mret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q <= epc_d;
      cause_q <= cause_d;
      mret_q <= mret_d;
    end
  end
  assign bus.csr_we_o = !rst & we;
  assign bus.csr_waddr_o = rst ? '0 : waddr;
  assign bus.csr_wdata_o = rst ? '0 : wdata;
  assign bus.stall_o = !rst & stall;
  assign bus.flush_o = !rst & flush;
  assign bus.jump_o = !rst & jump;
  assign bus.jump_addr_o = (rst || !jump) ? '0 : jaddr;
endmodule
